// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Entry width for a given PC width; the packed {pc, instr} struct is built in fetch_unit.
  function automatic int entry_w(input int pc_w);
    return pc_w + INSTR_W;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: circular buffer, pointers one bit wider than the index so full/empty are unambiguous.
// Flush wins over push and pop; pop on empty is ignored.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 44
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic [W-1:0]             head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         wr_en;
  logic [W-1:0] mem_q [DEPTH];

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues at most one outstanding imem request, buffers words in a prefetch FIFO.
// Head of the FIFO drives the decode outputs; redirect flushes and marks any in-flight response stale.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int             CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;

  logic             fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     push_entry, head_entry;

  // Request depends on registered state only (plus reset gating), never on this cycle's inputs.
  assign imem_req  = (state_q == IDLE) && (fifo_count < DEPTH_C) && !rst;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    fifo_push  = 1'b0;
    fifo_pop   = !fifo_empty && !stall;
    fifo_flush = 1'b0;
    push_entry = '{pc: req_pc_q, instr: imem_rdata};

    unique case (state_q)
      IDLE: begin
        if (imem_req && imem_gnt) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_W'(4);
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          fifo_push = 1'b1;
          state_d   = IDLE;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything; a request still in flight afterwards must be discarded on return.
    if (redirect) begin
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fetch_pc_d = redirect_pc;
      if ((state_q == IDLE && imem_req && imem_gnt) ||
          ((state_q == WAIT || state_q == DROP) && !imem_rvalid)) begin
        state_d = DROP;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (entry_w(PC_W))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (push_entry),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .head     (head_entry)
  );

  assign if_valid = !fifo_empty;
  assign if_instr = if_valid ? head_entry.instr : NOP_INSTR;
  assign if_pc    = if_valid ? head_entry.pc    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table, hand sequences, and randomized traffic against an in-order PC-stream model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [11:0] RST_PC  = 12'h000;
  localparam logic [11:0] RST_PC2 = 12'hFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0, stall = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [11:0] if_pc;

  logic        redirect2 = 1'b0, stall2 = 1'b0, imem_gnt2 = 1'b1, imem_rvalid2 = 1'b0;
  logic [11:0] redirect_pc2 = '0;
  logic        imem_req2, if_valid2;
  logic [11:0] imem_addr2, if_pc2;
  logic [31:0] imem_rdata2 = '0, if_instr2;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(12), .DEPTH(4), .RESET_PC(RST_PC)) u_dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc));

  fetch_unit #(.PC_W(12), .DEPTH(4), .RESET_PC(RST_PC2)) u_dut2 (
    .clk(clk), .rst(rst), .redirect(redirect2), .redirect_pc(redirect_pc2), .stall(stall2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2));

  int n_vec = 0, n_err = 0, n_pop = 0;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] word_of(input logic [11:0] a);
    return {8'hA5, a, ~a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next PC decode should see, and next PC the unit should request.
  logic [11:0] exp_pc, exp_req, exp2;
  logic        redir_prev;
  // Behavioural memory: one response slot with configurable latency.
  int          mem_lat = 1, gnt_pct = 100, mem_cnt = 0;
  logic        mem_busy = 1'b0;
  logic [11:0] mem_addr = '0;
  logic        pend2 = 1'b0;
  logic [11:0] pend2_addr = '0;
  logic [11:0] wrap_seq [3];
  int          n_wrap = 0;

  // Advances one clock; services the second (wrap) instance, which has a zero-wait memory.
  task automatic do_edge();
    logic        nxt2;
    logic [11:0] a2;
    nxt2 = imem_req2;
    a2   = imem_addr2;
    @(posedge clk);
    pend2      = nxt2;
    pend2_addr = a2;
    @(negedge clk);
    imem_rvalid2 = pend2;
    imem_rdata2  = word_of(pend2_addr);
    if (if_valid2) begin
      chk("wrap if_pc", if_pc2, exp2);
      chk("wrap if_instr", if_instr2, word_of(exp2));
      if (n_wrap < 3) wrap_seq[n_wrap] = if_pc2;
      n_wrap++;
      exp2 = exp2 + 12'd4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; mem_busy = 1'b0; pend2 = 1'b0; imem_rvalid2 = 1'b0;
    #1;
    chk("reset imem_req", imem_req, 0);
    chk("reset if_valid", if_valid, 0);
    chk("reset if_instr", if_instr, NOP_INSTR);
    chk("reset if_pc", if_pc, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pc = RST_PC; exp_req = RST_PC; redir_prev = 1'b0; exp2 = RST_PC2;
  endtask

  // One model-checked cycle; caller sets stall/redirect/redirect_pc beforehand.
  task automatic tick();
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? word_of(mem_addr) : 32'hDEAD_BEEF;
    imem_gnt    = imem_req && !mem_busy && ($urandom_range(0, 99) < gnt_pct);
    #1;
    if (redir_prev) chk("if_valid after redirect", if_valid, 0);
    if (if_valid) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_instr", if_instr, word_of(exp_pc));
    end else begin
      chk("idle if_instr", if_instr, NOP_INSTR);
      chk("idle if_pc", if_pc, 0);
    end
    if (imem_req && imem_gnt) chk("imem_addr", imem_addr, exp_req);
    if (redirect) begin
      exp_pc  = redirect_pc;
      exp_req = redirect_pc;
    end else begin
      if (if_valid && !stall) begin
        exp_pc = exp_pc + 12'd4;
        n_pop++;
      end
      if (imem_req && imem_gnt) exp_req = exp_req + 12'd4;
    end
    redir_prev = redirect;
    if (imem_rvalid) mem_busy = 1'b0;
    if (imem_gnt) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = mem_lat - 1;
    end else if (mem_busy && !imem_rvalid) begin
      mem_cnt--;
    end
    do_edge();
  endtask

  typedef struct {
    logic        stall, redir;
    logic [11:0] rpc;
    logic        gnt, rv, e_req;
    logic [11:0] e_addr;
    logic        e_valid;
    logic [11:0] e_pc;
  } vec_t;

  function automatic vec_t v(input logic s, input logic r, input logic [11:0] rp,
                             input logic g, input logic rv, input logic er,
                             input logic [11:0] ea, input logic ev, input logic [11:0] ep);
    vec_t x;
    x.stall = s; x.redir = r; x.rpc = rp; x.gnt = g; x.rv = rv;
    x.e_req = er; x.e_addr = ea; x.e_valid = ev; x.e_pc = ep;
    return x;
  endfunction

  initial begin
    vec_t        tbl [17];
    logic [11:0] last_gnt;
    bit          seen;

    for (int i = 0; i < 3; i++) wrap_seq[i] = 12'h555;

    // Cycle 0 is the first cycle after reset release; gnt same cycle, rvalid one cycle later.
    //            stall rdr rpc     gnt rv  req addr    vld pc
    tbl[0]  = v(0, 0, 12'h000, 1, 0, 1, 12'h000, 0, 12'h000);
    tbl[1]  = v(0, 0, 12'h000, 0, 1, 0, 12'h000, 0, 12'h000);
    tbl[2]  = v(0, 0, 12'h000, 1, 0, 1, 12'h004, 1, 12'h000);
    tbl[3]  = v(0, 0, 12'h000, 0, 1, 0, 12'h000, 0, 12'h000);
    tbl[4]  = v(1, 0, 12'h000, 1, 0, 1, 12'h008, 1, 12'h004);
    tbl[5]  = v(0, 1, 12'h100, 0, 0, 0, 12'h000, 1, 12'h004);  // redirect while WAIT
    tbl[6]  = v(0, 0, 12'h000, 0, 1, 0, 12'h000, 0, 12'h000);  // stale word for 0x008
    tbl[7]  = v(0, 0, 12'h000, 1, 0, 1, 12'h100, 0, 12'h000);
    tbl[8]  = v(0, 0, 12'h000, 0, 1, 0, 12'h000, 0, 12'h000);
    tbl[9]  = v(0, 0, 12'h000, 0, 0, 1, 12'h104, 1, 12'h100);  // no gnt: address held
    tbl[10] = v(0, 0, 12'h000, 1, 0, 1, 12'h104, 0, 12'h000);
    tbl[11] = v(0, 1, 12'h200, 0, 1, 0, 12'h000, 0, 12'h000);  // redirect with rvalid
    tbl[12] = v(0, 1, 12'h300, 1, 0, 1, 12'h200, 0, 12'h000);  // redirect with req&&gnt
    tbl[13] = v(0, 0, 12'h000, 0, 1, 0, 12'h000, 0, 12'h000);
    tbl[14] = v(0, 0, 12'h000, 1, 0, 1, 12'h300, 0, 12'h000);
    tbl[15] = v(0, 0, 12'h000, 0, 1, 0, 12'h000, 0, 12'h000);
    tbl[16] = v(0, 0, 12'h000, 0, 0, 1, 12'h304, 1, 12'h300);

    do_reset();
    last_gnt = '0;
    for (int i = 0; i < 17; i++) begin
      stall       = tbl[i].stall;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      imem_gnt    = tbl[i].gnt;
      imem_rvalid = tbl[i].rv;
      imem_rdata  = tbl[i].rv ? word_of(last_gnt) : 32'hDEAD_BEEF;
      #1;
      chk($sformatf("tbl%0d imem_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("tbl%0d imem_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d if_valid", i), if_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d if_pc", i), if_pc, tbl[i].e_valid ? tbl[i].e_pc : 12'h000);
      chk($sformatf("tbl%0d if_instr", i), if_instr,
          tbl[i].e_valid ? word_of(tbl[i].e_pc) : NOP_INSTR);
      if (imem_gnt && imem_req) last_gnt = imem_addr;
      do_edge();
    end
    redirect = 1'b0;

    // Stall for 12 cycles: FIFO fills, requests stop, then drains in order and resumes at 0x010.
    do_reset();
    mem_lat = 1; gnt_pct = 100; stall = 1'b1;
    repeat (12) tick();
    chk("full imem_req", imem_req, 0);
    chk("full if_valid", if_valid, 1);
    stall = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("drain if_pc", if_pc, 12'(k * 4));
      if (imem_req && !seen) begin
        chk("resume addr", imem_addr, 12'h010);
        seen = 1'b1;
      end
      tick();
    end
    chk("resume seen", seen, 1);

    // Reset pulsed in WAIT with latency 3; the late response must be ignored.
    do_reset();
    mem_lat = 3; gnt_pct = 100; stall = 1'b1;
    repeat (5) tick();
    chk("pre-reset if_valid", if_valid, 1);
    rst = 1'b1;
    #1;
    chk("async rst if_valid", if_valid, 0);
    chk("async rst if_instr", if_instr, NOP_INSTR);
    chk("async rst if_pc", if_pc, 0);
    chk("async rst imem_req", imem_req, 0);
    exp_pc = RST_PC; exp_req = RST_PC; redir_prev = 1'b0; exp2 = RST_PC2;
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (if_valid) begin
        chk("restart if_pc", if_pc, RST_PC);
        seen = 1'b1;
      end
      tick();
    end
    chk("restart delivered", seen, 1);

    // Randomized traffic across latencies and grant rates.
    do_reset();
    n_pop = 0;
    for (int seg = 0; seg < 8; seg++) begin
      mem_lat = 1 + (seg % 4);
      gnt_pct = (seg < 4) ? 100 : 40;
      for (int c = 0; c < 400; c++) begin
        stall       = ($urandom_range(0, 3) == 0);
        redirect    = ($urandom_range(0, 15) == 0);
        redirect_pc = 12'($urandom_range(0, 1023) * 4);
        tick();
      end
    end
    redirect = 1'b0;
    chk("forward progress", n_pop > 100, 1);

    chk("wrap pc0", wrap_seq[0], 12'hFF8);
    chk("wrap pc1", wrap_seq[1], 12'hFFC);
    chk("wrap pc2", wrap_seq[2], 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the fetch/decode pipeline register. It owns the fetch PC and issues requests to a variable-latency instruction memory over a req/gnt/rvalid handshake. Returned words are buffered in a small prefetch FIFO that decode drains, with stall and branch-redirect handling. It replaces direct PC-register-to-instruction-memory wiring; `redirect`/`redirect_pc` come from the branch decision and PC mux path, and `stall` is the inverse of the hazard unit's fetch/decode write enable.

## Interface
- `PC_W`, 12: fetch PC width, byte address.
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `RESET_PC`, 0: first fetch address after reset.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `redirect`  in  1  taken branch/jump; flush and refetch.
- `redirect_pc`  in  PC_W  new fetch address, valid with `redirect`.
- `stall`  in  1  decode not accepting; head entry held.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PC_W  request address, stable while `imem_req` high.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; ≥1 cycle after its `gnt`.
- `imem_rdata`  in  32  response instruction word.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a real instruction.
- `if_instr`  out  32  head instruction; NOP (32'h00000013) when `if_valid`=0.
- `if_pc`  out  PC_W  PC of head instruction; 0 when `if_valid`=0.

## Operation
- States: IDLE (no outstanding request), WAIT (one outstanding, live), DROP (one outstanding, stale). At most one outstanding request.
- `imem_req` = (state==IDLE) && (count<DEPTH) && !rst. Registered-state decode only; no combinational path from any input to `imem_req`.
- `imem_addr` = `fetch_pc`. FIFO entries carry {pc, instr}.
- IDLE: `req && gnt` -> WAIT, `fetch_pc` += 4, modulo 2^PC_W.
- WAIT: `rvalid` -> push {pc_of_request, rdata}, then IDLE.
- DROP: `req` low; `rvalid` -> discard, then IDLE.
- Pop: `if_valid && !stall` removes head at the clock edge. Push and pop in the same cycle leave count unchanged. Push never overflows: requests are issued only with count<DEPTH.
- `redirect` has priority over push, pop, and stall:
  - FIFO cleared.
  - `fetch_pc` <= `redirect_pc`.
  - A response arriving the same cycle is discarded.
  - State is DROP if a request is outstanding after this cycle (WAIT without `rvalid`, or IDLE with `req && gnt`). Otherwise state is IDLE.
- `redirect_pc` is used as given; bits [1:0] are not checked.

## Timing
- Reset values: state IDLE, `fetch_pc`=RESET_PC, FIFO empty, `imem_req`=0, `if_valid`=0, `if_instr`=NOP, `if_pc`=0.
- First `imem_req` is in the first cycle after `rst` deasserts.
- Outputs come from the FIFO head register: a word pushed at edge N is visible at `if_*` in cycle N+1.
- With same-cycle `gnt` and next-cycle `rvalid`: request in cycle 0, response in cycle 1, `if_valid` in cycle 2, next request in cycle 2. Sustained throughput is 1 instruction per 2 cycles.
- `redirect` in cycle N: `if_valid`=0 in cycle N+1. Request for `redirect_pc` in cycle N+1 if no request is outstanding; otherwise one cycle after the stale `rvalid`.
- Reset asserted mid-transaction: all state clears immediately. A late `rvalid` after reset release, while IDLE, is ignored.
- `rvalid` while IDLE is ignored.

## Structure
- Package `fetch_pkg`:
  - `NOP_INSTR` = 32'h00000013.
  - State enum `fetch_state_t` {IDLE, WAIT, DROP}.
  - Entry struct {pc, instr}; PC_W is passed as a parameter.
- Sub-module `fetch_fifo`:
  - Parameters: DEPTH, entry width.
  - Ports: push, pop, flush (priority), count, empty, head.
  - Circular buffer with pointers one bit wider than log2(DEPTH).
- `fetch_unit` holds the FSM, `fetch_pc`, the request-PC register, and output muxing. Target 150–250 lines in total.

## Test plan
- Reset release, RESET_PC=0, `gnt` same cycle, `rvalid` +1 cycle:
  - Requests at addresses 0x000, 0x004, 0x008.
  - `if_valid` first high 2 cycles after the first request, with `if_pc`=0x000.
- `stall` held high for 12 cycles:
  - FIFO fills to 4 entries and `imem_req` drops.
  - On release, outputs pop 4 entries in order with no loss, then fetching resumes at 0x010.
- Redirect to 0x100 while in WAIT:
  - Old response is discarded.
  - `if_valid`=0 next cycle.
  - Next request address is 0x100; the first output is `if_pc`=0x100.
- Redirect coinciding with `imem_rvalid`, and separately with `req && gnt`:
  - Neither word is delivered.
  - No duplicate or stale PC ever appears.
- Wrap-around: RESET_PC=0xFF8:
  - Fetch order is 0xFF8, 0xFFC, 0x000.
- `rst` pulsed while in WAIT with memory latency 3:
  - Outputs return to their reset values asynchronously.
  - The late `rvalid` is ignored.
  - Fetch restarts at RESET_PC.
